dut_req_arbiter: RTL and testbench
==================================

// Module: dut_req_arbiter
// PURPOSE
//  Shares the single stimulus input port of dut_top among NUM_REQ requesters (agent drivers/BFMs).
//  Packet-granular round-robin arbitration with valid/ready handshakes on both sides.
//  A grant is held until the packet's last beat, or until the idle watchdog fires.
//  Sits between the requester interfaces and dut_top, clocked by the testbench clk.
// PARAMETERS
//  NUM_REQ       4   number of requesters, >=2
//  DATA_W        32  beat payload width
//  IDLE_TIMEOUT  64  idle cycles allowed in a locked packet before forced release; 0 = watchdog off
//  ID_W          $clog2(NUM_REQ)  derived, not overridden
// PORTS
//  clk          in   1                 single clock, all logic on posedge
//  rst          in   1                 synchronous, active-high reset
//  req_valid    in   NUM_REQ           per-requester beat valid
//  req_last     in   NUM_REQ           per-requester last beat of packet
//  req_data     in   NUM_REQ*DATA_W    requester i occupies bits [i*DATA_W +: DATA_W]
//  req_ready    out  NUM_REQ           per-requester beat accept
//  out_valid    out  1                 beat valid toward dut_top
//  out_data     out  DATA_W            beat payload
//  out_last     out  1                 last beat of packet
//  out_id       out  ID_W              index of the requester that sourced the beat
//  out_ready    in   1                 dut_top accepts beat
//  timeout_err  out  1                 one-cycle pulse on watchdog release
//  busy         out  1                 (state==LOCK) || out_valid
// BEHAVIOUR
//  Reset: state=IDLE; rr_ptr=0; grant=0; idle_cnt=0; out_valid/out_last/timeout_err=0.
//   out_data=0; out_id=0; req_ready=0. Reset mid-packet drops the beat held in the output register.
//  FSM IDLE: if any req_valid, pick the first set index searching rr_ptr, rr_ptr+1, ... (mod NUM_REQ).
//   grant<=idx, ->LOCK. No beat is accepted in IDLE.
//  FSM LOCK: req_ready[i] = (i==grant) && (!out_valid || out_ready), combinational. Other ready bits are 0.
//   Accepted beat (valid&&ready): out_data/out_last/out_id<=beat/grant; out_valid<=1; idle_cnt<=0.
//   Accepted beat with req_last: rr_ptr<=(grant+1) mod NUM_REQ, ->IDLE.
//   Granted req_valid low: idle_cnt++. When idle_cnt==IDLE_TIMEOUT-1 and still low:
//    timeout_err<=1 for one cycle; rr_ptr<=grant+1; ->IDLE; idle_cnt<=0.
//    Dut_top then sees a truncated packet (no out_last). This is by design.
//   A granted valid held high but stalled by out_ready does not count as idle.
//  Output register: out_valid clears on out_ready when no new beat is loaded.
//   out_* hold stable while out_valid && !out_ready.
//   Simultaneous drain + load in the same cycle is allowed: 1 beat/clk sustained.
//  Latency: req_valid seen in IDLE at edge t -> grant at t+1 -> first req_ready in the cycle after t+1.
//   out_valid follows at t+2. Packet-to-packet bubble is 1 cycle (IDLE arbitration).
//  Fairness: after any release, the released index has lowest priority.
//   Lone requester re-granted back-to-back. rr_ptr wraps NUM_REQ-1 -> 0.
//  Single-beat packet (valid&&last on the first beat): LOCK for one accept, then IDLE.
// STRUCTURE
//  Package dut_arb_pkg: typedef enum logic {ARB_IDLE, ARB_LOCK} arb_state_e.
//   Also holds function rr_next(ptr, n) for the mod-N increment.
//  Sub-module rr_pick #(N): combinational rotating-priority encoder (req vector, ptr -> idx, found).
//  Top holds the FSM, rr_ptr, idle_cnt, output register, and ready decode.
// TESTING
//  1 Reset: rst high 3 cycles with req_valid=4'b1111 -> all outputs 0.
//     First grant is id 0 two cycles after rst drops.
//  2 Round-robin: all 4 valid, 2-beat packets, out_ready=1 -> out_id sequence 0,1,2,3,0.
//     Each packet is 2 beats + 1 idle cycle.
//  3 Backpressure: out_ready=0 for 5 cycles mid-packet -> out_data stable, req_ready=0.
//     No beat lost or duplicated after release.
//  4 Watchdog: IDLE_TIMEOUT=8, grantee drops valid after beat 1 -> timeout_err pulse 8 cycles later.
//     Next requester is granted and busy stays consistent.
//  5 Lone/wrap: only req 3 valid, 5 single-beat packets -> 5 back-to-back grants to id 3.
//     rr_ptr wraps to 0 each time.
//  6 Reset mid-packet: assert rst during beat 2 of 4 -> out_valid=0 next cycle.
//     Arbitration restarts from id 0.

Source files
------------

// File: rtl/dut_arb_pkg.sv
// rtl/dut_arb_pkg.sv - shared types and helpers for the requester arbiter
//
// Purpose: FSM state type and the modulo-N pointer increment used by the
// arbiter and its rotating-priority picker.
// Ports: none (package).
package dut_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_e;

  // Next index after ptr, wrapping n-1 back to 0.
  function automatic int rr_next(input int ptr, input int n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/dut_req_arbiter_rr_pick.sv
// rtl/dut_req_arbiter_rr_pick.sv - rotating-priority encoder for the arbiter
//
// Purpose: returns the first asserted request found when searching from
// ptr_i upward, wrapping modulo N.
// Ports:
//   req_i    in   N   request vector
//   ptr_i    in   W   index holding highest priority
//   idx_o    out  W   selected index (0 when nothing requested)
//   found_o  out  1   at least one request asserted
module rr_pick
  import dut_arb_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [W-1:0] idx_o,
  output logic         found_o
);

  int cand;

  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    cand    = int'(ptr_i);
    for (int k = 0; k < N; k++) begin
      if (!found_o && req_i[W'(cand)]) begin
        idx_o   = W'(cand);
        found_o = 1'b1;
      end
      cand = rr_next(cand, N);
    end
  end

endmodule

// File: rtl/dut_req_arbiter.sv
// rtl/dut_req_arbiter.sv - packet-granular round-robin arbiter in front of dut_top
//
// Purpose: shares one valid/ready stimulus port among NUM_REQ requesters.
// A grant is held for a whole packet (until the beat with req_last) or until
// the idle watchdog releases it. Output is a single registered beat stage.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   req_valid/req_last/req_data   per-requester beat inputs (data packed i*DATA_W)
//   req_ready     per-requester beat accept (combinational)
//   out_valid/out_data/out_last/out_id   registered beat toward dut_top
//   out_ready     dut_top accepts beat
//   timeout_err   one-cycle pulse when the watchdog forces a release
//   busy          locked on a requester or holding an output beat
module dut_req_arbiter
  import dut_arb_pkg::*;
#(
  parameter  int NUM_REQ      = 4,
  parameter  int DATA_W       = 32,
  parameter  int IDLE_TIMEOUT = 64,
  localparam int ID_W         = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_last,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_last,
  output logic [ID_W-1:0]           out_id,
  input  logic                      out_ready,
  output logic                      timeout_err,
  output logic                      busy
);

  localparam int CNT_W = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;

  arb_state_e        state_q, state_d;
  logic [ID_W-1:0]   grant_q, grant_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]  idle_cnt_q, idle_cnt_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic [ID_W-1:0]   out_id_q, out_id_d;
  logic              timeout_q, timeout_d;

  logic [ID_W-1:0]   pick_idx;
  logic              pick_found;
  logic              out_free;
  logic              accept;
  logic              grant_valid;
  logic              grant_last;
  logic [DATA_W-1:0] grant_data;
  logic [ID_W-1:0]   grant_inc;

  rr_pick #(.N(NUM_REQ), .W(ID_W)) u_pick (
    .req_i   (req_valid),
    .ptr_i   (rr_ptr_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  // The output stage can take a beat when empty or draining this cycle.
  assign out_free    = !out_valid_q || out_ready;
  assign grant_valid = req_valid[grant_q];
  assign grant_last  = req_last[grant_q];
  assign grant_inc   = ID_W'(rr_next(int'(grant_q), NUM_REQ));
  assign accept      = (state_q == ARB_LOCK) && grant_valid && out_free;

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == ID_W'(i)) grant_data = req_data[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == ARB_LOCK) req_ready[grant_q] = out_free;
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    idle_cnt_d  = idle_cnt_q;
    out_valid_d = out_valid_q && !out_ready;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_id_d    = out_id_q;
    timeout_d   = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        idle_cnt_d = '0;
        if (pick_found) begin
          grant_d = pick_idx;
          state_d = ARB_LOCK;
        end
      end
      ARB_LOCK: begin
        if (accept) begin
          out_valid_d = 1'b1;
          out_data_d  = grant_data;
          out_last_d  = grant_last;
          out_id_d    = grant_q;
          idle_cnt_d  = '0;
          if (grant_last) begin
            rr_ptr_d = grant_inc;
            state_d  = ARB_IDLE;
          end
        end else if (!grant_valid && (IDLE_TIMEOUT != 0)) begin
          // Only a silent grantee counts as idle; a stalled valid does not.
          if (idle_cnt_q == CNT_W'(IDLE_TIMEOUT - 1)) begin
            timeout_d  = 1'b1;
            rr_ptr_d   = grant_inc;
            state_d    = ARB_IDLE;
            idle_cnt_d = '0;
          end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      idle_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_id_q    <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      idle_cnt_q  <= idle_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_id_q    <= out_id_d;
      timeout_q   <= timeout_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_last    = out_last_q;
  assign out_id      = out_id_q;
  assign timeout_err = timeout_q;
  assign busy        = (state_q == ARB_LOCK) || out_valid_q;

endmodule

// File: tb/tb_dut_req_arbiter.sv
// tb/tb_dut_req_arbiter.sv - self-checking bench for dut_req_arbiter
module tb_dut_req_arbiter;

  localparam int NR = 4;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [NR-1:0] req_valid, req_last, req_ready;
  logic [NR*DW-1:0] req_data;
  logic          out_valid, out_last, out_ready, timeout_err, busy;
  logic [DW-1:0] out_data;
  logic [1:0]    out_id;

  dut_req_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .IDLE_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
    .req_ready(req_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_id(out_id), .out_ready(out_ready),
    .timeout_err(timeout_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model: owner = -1 when nobody holds the port.
  int            m_owner, m_prio, m_idle, m_oid, m_to_id;
  bit            m_ov, m_ol, m_to;
  logic [DW-1:0] m_od;

  // Requester stimulus state.
  bit en[NR];
  bit present[NR];
  int beat_idx[NR];
  int pkt_len[NR];
  int pkt_cnt[NR];
  int silent_at[NR];
  int gap_pct, len_min, len_max;

  int exp_rr[5] = '{0, 1, 2, 3, 0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_prio = 0; m_idle = 0;
    m_ov = 0; m_ol = 0; m_od = '0; m_oid = 0; m_to = 0; m_to_id = 0;
  endtask

  function automatic logic [NR-1:0] exp_ready();
    logic [NR-1:0] r = '0;
    for (int i = 0; i < NR; i++)
      if (m_owner == i && (!m_ov || out_ready)) r[i] = 1'b1;
    return r;
  endfunction

  // Advances the model by one clock using the inputs currently applied.
  task automatic model_edge();
    int o;
    m_to = 0;
    if (rst) begin
      model_reset();
      return;
    end
    if (m_owner < 0) begin
      if (m_ov && out_ready) m_ov = 0;
      for (int k = 0; k < NR; k++) begin
        o = (m_prio + k) % NR;
        if (req_valid[o]) begin
          m_owner = o;
          break;
        end
      end
    end else begin
      o = m_owner;
      if (req_valid[o] && (!m_ov || out_ready)) begin
        m_ov = 1; m_od = req_data[o*DW +: DW]; m_ol = req_last[o]; m_oid = o; m_idle = 0;
        if (req_last[o]) begin
          m_prio  = (o + 1) % NR;
          m_owner = -1;
        end
      end else begin
        if (m_ov && out_ready) m_ov = 0;
        if (!req_valid[o]) begin
          m_idle++;
          if (m_idle == TO) begin
            m_to = 1; m_to_id = o; m_prio = (o + 1) % NR; m_owner = -1; m_idle = 0;
          end
        end
      end
    end
  endtask

  function automatic logic [31:0] beat_word(input int i);
    int p, b;
    p = pkt_cnt[i];
    b = beat_idx[i];
    return {i[7:0], p[7:0], b[15:0]};
  endfunction

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      req_valid[i]          = present[i];
      req_last[i]           = present[i] && (beat_idx[i] == pkt_len[i] - 1);
      req_data[i*DW +: DW]  = beat_word(i);
    end
  endtask

  task automatic bfm_update(input logic [NR-1:0] acc);
    for (int i = 0; i < NR; i++) begin
      if (acc[i]) begin
        present[i] = 0;
        if (beat_idx[i] == pkt_len[i] - 1) begin
          beat_idx[i] = 0;
          pkt_cnt[i]++;
        end else begin
          beat_idx[i]++;
        end
      end
    end
    if (m_to) begin
      beat_idx[m_to_id] = 0; pkt_cnt[m_to_id]++; silent_at[m_to_id] = -1; present[m_to_id] = 0;
    end
    for (int i = 0; i < NR; i++) begin
      if ((en[i] || beat_idx[i] != 0) && !present[i] && silent_at[i] != beat_idx[i]) begin
        if ($urandom_range(99) >= gap_pct) begin
          if (beat_idx[i] == 0) pkt_len[i] = $urandom_range(len_max, len_min);
          present[i] = 1;
        end
      end
    end
    drive();
  endtask

  task automatic bfm_reset();
    for (int i = 0; i < NR; i++) begin
      present[i] = 0; beat_idx[i] = 0; pkt_cnt[i]++; silent_at[i] = -1;
    end
    bfm_update('0);
  endtask

  task automatic tick();
    logic [NR-1:0] acc;
    #1;
    chk("req_ready", 32'(req_ready), 32'(exp_ready()));
    acc = req_valid & req_ready;
    model_edge();
    @(posedge clk);
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("out_data", out_data, m_od);
    chk("out_last", 32'(out_last), 32'(m_ol));
    chk("out_id", 32'(out_id), 32'(m_oid));
    chk("timeout_err", 32'(timeout_err), 32'(m_to));
    chk("busy", 32'(busy), 32'(m_owner >= 0 || m_ov));
    bfm_update(acc);
  endtask

  task automatic drain();
    bit done = 0;
    out_ready = 1;
    for (int i = 0; i < NR; i++) begin en[i] = 0; silent_at[i] = -1; end
    for (int k = 0; k < 80 && !done; k++) begin
      tick();
      done = (m_owner < 0) && !m_ov;
      for (int i = 0; i < NR; i++) if (present[i] || beat_idx[i] != 0) done = 0;
    end
    chk("drain", 32'(done), 1);
  endtask

  initial begin
    int starts[$];
    int st_cyc[$];
    bit found;
    logic [DW-1:0] held;
    int n, cnt, last_c;

    rst = 1; out_ready = 1; req_valid = '0; req_last = '0; req_data = '0;
    for (int i = 0; i < NR; i++) begin
      en[i] = 1; present[i] = 0; beat_idx[i] = 0; pkt_len[i] = 2; pkt_cnt[i] = 0; silent_at[i] = -1;
    end
    gap_pct = 0; len_min = 2; len_max = 2;
    model_reset();
    bfm_update('0);
    @(posedge clk); #1;
    // Reset held with all requesters valid.
    tick(); tick();

    // Round-robin over 2-beat packets.
    rst = 0;
    for (int k = 1; k <= 30 && starts.size() < 5; k++) begin
      tick();
      if (k == 2) begin
        chk("first_grant_valid", 32'(out_valid), 1);
        chk("first_grant_id", 32'(out_id), 0);
      end
      if (out_valid && out_data[15:0] == 16'd0) begin
        starts.push_back(int'(out_id));
        st_cyc.push_back(k);
      end
    end
    chk("rr_count", starts.size(), 5);
    for (int j = 0; j < starts.size() && j < 5; j++) chk("rr_id", starts[j], exp_rr[j]);
    for (int j = 1; j < st_cyc.size(); j++) chk("rr_spacing", st_cyc[j] - st_cyc[j-1], 3);

    // Backpressure mid-packet.
    found = 0;
    for (int k = 0; k < 12 && !found; k++) begin
      tick();
      if (out_valid && out_data[15:0] == 16'd0) found = 1;
    end
    chk("bp_start", 32'(found), 1);
    held = out_data;
    out_ready = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_hold", out_data, held);
      chk("bp_ready", 32'(req_ready), 0);
    end
    out_ready = 1;
    for (int k = 0; k < 12; k++) tick();

    // Watchdog: requester 1 goes silent after its first beat.
    drain();
    len_min = 4; len_max = 4;
    silent_at[1] = 1; en[1] = 1;
    found = 0;
    for (int k = 0; k < 12 && !found; k++) begin
      tick();
      if (out_valid && out_id == 2'd1) found = 1;
    end
    chk("wd_first", 32'(found), 1);
    en[2] = 1;
    n = 0; found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      tick();
      n++;
      if (timeout_err) found = 1;
    end
    chk("wd_fired", 32'(found), 1);
    chk("wd_delay", n, TO);
    en[1] = 0;
    found = 0;
    for (int k = 0; k < 12 && !found; k++) begin
      tick();
      if (out_valid) found = 1;
    end
    chk("wd_next_valid", 32'(found), 1);
    chk("wd_next_id", 32'(out_id), 2);

    // Lone requester 3, single-beat packets.
    drain();
    len_min = 1; len_max = 1;
    en[3] = 1;
    cnt = 0; last_c = 0;
    for (int k = 0; k < 30 && cnt < 5; k++) begin
      tick();
      if (out_valid) begin
        chk("lone_id", 32'(out_id), 3);
        chk("lone_last", 32'(out_last), 1);
        if (cnt > 0) chk("lone_gap", k - last_c, 2);
        last_c = k;
        cnt++;
      end
    end
    chk("lone_count", cnt, 5);
    // Pointer wrapped past 3: requester 0 now outranks 3.
    drain();
    en[0] = 1; en[3] = 1;
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      tick();
      if (out_valid) found = 1;
    end
    chk("wrap_valid", 32'(found), 1);
    chk("wrap_first_id", 32'(out_id), 0);

    // Reset during beat 2 of a 4-beat packet.
    drain();
    len_min = 4; len_max = 4;
    for (int i = 0; i < NR; i++) en[i] = 1;
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      tick();
      if (out_valid && out_data[15:0] == 16'd1) found = 1;
    end
    chk("mid_beat2", 32'(found), 1);
    rst = 1;
    tick();
    chk("mid_rst_valid", 32'(out_valid), 0);
    rst = 0;
    bfm_reset();
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      tick();
      if (out_valid) found = 1;
    end
    chk("mid_restart_valid", 32'(found), 1);
    chk("mid_restart_id", 32'(out_id), 0);

    // Randomized traffic against the model.
    gap_pct = 25; len_min = 1; len_max = 4;
    for (int k = 0; k < 400; k++) begin
      out_ready = ($urandom_range(99) < 70);
      if (k % 25 == 0) for (int i = 0; i < NR; i++) en[i] = ($urandom_range(3) != 0);
      for (int i = 0; i < NR; i++)
        if (beat_idx[i] == 0 && silent_at[i] < 0 && $urandom_range(99) < 3)
          silent_at[i] = $urandom_range(3, 1);
      if ($urandom_range(199) == 0) begin
        rst = 1;
        tick();
        rst = 0;
        bfm_reset();
      end else begin
        tick();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
